// File: rtl/debug_ctrl_v2.sv
// debug_ctrl_v2: run/halt/N-step debug controller with Avalon-MM slave regs, PC breakpoints and a halted-only access bridge.
// Latency: CTRL write sampled at edge N changes state at edge N+1; readdata is valid one cycle after the read; breakpoint gating is zero-cycle.
// Backpressure: no waitrequest, the slave always accepts; the access bridge holds tx_flag until done_sending is sampled in CMD.
// Ports: CLK/RST (sync, active-low); avs_* Avalon-MM slave; pc_in/pc_valid from core fetch;
//        data_internal/done_sending from the access path; debug, enable_ext, enable_pc_ext to core;
//        tx_flag, address_bridged, data_bridged, mode drive the access path.
module debug_ctrl_v2 #(
   parameter int NUM_BP = 4,
   parameter int NUM_EN = 4,
   parameter int STEP_W = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              avs_chipselect,
   input  logic [3:0]        avs_address,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   input  logic              avs_read,
   output logic [31:0]       avs_readdata,
   input  logic [31:0]       pc_in,
   input  logic              pc_valid,
   input  logic [31:0]       data_internal,
   input  logic              done_sending,
   output logic              debug,
   output logic [NUM_EN-1:0] enable_ext,
   output logic              enable_pc_ext,
   output logic              tx_flag,
   output logic [31:0]       address_bridged,
   output logic [31:0]       data_bridged,
   output logic [2:0]        mode
);

   localparam logic [1:0] S_HALTED = 2'd0;
   localparam logic [1:0] S_RUN    = 2'd1;
   localparam logic [1:0] S_STEP   = 2'd2;
   localparam logic [1:0] S_CMD    = 2'd3;

   localparam logic [3:0] A_CTRL    = 4'd0;
   localparam logic [3:0] A_STATUS  = 4'd1;
   localparam logic [3:0] A_ADDR    = 4'd2;
   localparam logic [3:0] A_WDATA   = 4'd3;
   localparam logic [3:0] A_RDATA   = 4'd4;
   localparam logic [3:0] A_STEPCNT = 4'd5;
   localparam logic [3:0] A_BPEN    = 4'd6;

   localparam logic [2:0] C_HOST = 3'd1;
   localparam logic [2:0] C_STEP = 3'd2;
   localparam logic [2:0] C_BP   = 3'd3;

   localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

   logic [1:0]        state;
   logic [2:0]        cmd_mode;
   logic [31:0]       addr_reg;
   logic [31:0]       wdata_reg;
   logic [31:0]       rdata_reg;
   logic [STEP_W-1:0] step_cnt;
   logic [STEP_W-1:0] step_ctr;
   logic [NUM_BP-1:0] bp_en;
   logic [NUM_BP-1:0] bp_hit;
   logic [31:0]       bp_addr [NUM_BP];
   logic              cmd_done;
   logic [2:0]        halt_cause;
   // Set on leaving HALTED so the core can restart from a breakpoint address.
   logic              bp_skip;

   // CTRL pulses are registered so the state change lands one edge after the write.
   logic              halt_req;
   logic              resume_req;
   logic              step_req;
   logic              go_req;

   logic              wr_en;
   logic              status_clr;
   logic              active;
   logic [NUM_BP-1:0] bp_match;
   logic              bp_any;
   logic              run_en;
   logic              cmd_tx;
   logic [31:0]       rd_mux;

   assign wr_en      = avs_chipselect && avs_write;
   assign status_clr = wr_en && (avs_address == A_STATUS);
   assign active     = (state == S_RUN) || (state == S_STEP);

   always_comb begin
      bp_match = '0;
      for (int i = 0; i < NUM_BP; i++) begin
         if (bp_en[i] && (pc_in == bp_addr[i])) begin
            bp_match[i] = 1'b1;
         end
      end
      if (!(pc_valid && active && !bp_skip)) begin
         bp_match = '0;
      end
   end

   assign bp_any = |bp_match;
   // The matching instruction is blocked in the same cycle (zero skid).
   assign run_en = ((state == S_RUN) || ((state == S_STEP) && (step_ctr != '0))) && !bp_any;
   assign cmd_tx = (state == S_CMD) &&
                   ((cmd_mode == 3'b001) || (cmd_mode == 3'b010) || (cmd_mode == 3'b101));

   assign debug           = (state == S_HALTED) || (state == S_CMD);
   assign enable_ext      = {NUM_EN{run_en}};
   assign enable_pc_ext   = run_en;
   assign tx_flag         = cmd_tx;
   assign address_bridged = addr_reg;
   assign data_bridged    = wdata_reg;
   assign mode            = (state == S_CMD) ? cmd_mode : 3'b000;

   always_comb begin
      rd_mux = '0;
      case (avs_address)
         A_CTRL:    rd_mux[6:4] = cmd_mode;
         A_STATUS: begin
            rd_mux[1:0]          = state;
            rd_mux[2]            = (state == S_CMD);
            rd_mux[3]            = cmd_done;
            rd_mux[6:4]          = halt_cause;
            rd_mux[8 +: NUM_BP]  = bp_hit;
         end
         A_ADDR:    rd_mux = addr_reg;
         A_WDATA:   rd_mux = wdata_reg;
         A_RDATA:   rd_mux = rdata_reg;
         A_STEPCNT: rd_mux[STEP_W-1:0] = step_cnt;
         A_BPEN:    rd_mux[NUM_BP-1:0] = bp_en;
         default: begin
            for (int i = 0; i < NUM_BP; i++) begin
               if (avs_address == 4'(8 + i)) begin
                  rd_mux = bp_addr[i];
               end
            end
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state        <= S_HALTED;
         cmd_mode     <= 3'b000;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         rdata_reg    <= '0;
         step_cnt     <= '0;
         step_ctr     <= '0;
         bp_en        <= '0;
         bp_hit       <= '0;
         cmd_done     <= 1'b0;
         halt_cause   <= 3'd0;
         bp_skip      <= 1'b0;
         halt_req     <= 1'b0;
         resume_req   <= 1'b0;
         step_req     <= 1'b0;
         go_req       <= 1'b0;
         avs_readdata <= '0;
         for (int i = 0; i < NUM_BP; i++) begin
            bp_addr[i] <= '0;
         end
      end else begin
         halt_req   <= 1'b0;
         resume_req <= 1'b0;
         step_req   <= 1'b0;
         go_req     <= 1'b0;

         // Register file writes; CTRL/ADDR/WDATA are frozen while a command is in flight.
         if (wr_en) begin
            case (avs_address)
               A_CTRL: begin
                  if (state != S_CMD) begin
                     halt_req   <= avs_writedata[0];
                     resume_req <= avs_writedata[1];
                     step_req   <= avs_writedata[2];
                     cmd_mode   <= avs_writedata[6:4];
                     go_req     <= avs_writedata[7];
                  end
               end
               A_STATUS:  cmd_done <= 1'b0;
               A_ADDR:    if (state != S_CMD) addr_reg <= avs_writedata;
               A_WDATA:   if (state != S_CMD) wdata_reg <= avs_writedata;
               A_STEPCNT: step_cnt <= avs_writedata[STEP_W-1:0];
               A_BPEN:    bp_en <= avs_writedata[NUM_BP-1:0];
               default: begin
                  for (int i = 0; i < NUM_BP; i++) begin
                     if (avs_address == 4'(8 + i)) begin
                        bp_addr[i] <= avs_writedata;
                     end
                  end
               end
            endcase
         end

         if (avs_chipselect && avs_read) begin
            avs_readdata <= rd_mux;
         end

         // A new hit in the same cycle as a clear still sticks.
         bp_hit <= (status_clr ? '0 : bp_hit) | bp_match;

         case (state)
            S_HALTED: begin
               if (go_req) begin
                  state <= S_CMD;
               end else if (step_req) begin
                  step_ctr <= step_cnt;
                  bp_skip  <= 1'b1;
                  state    <= S_STEP;
               end else if (resume_req) begin
                  bp_skip <= 1'b1;
                  state   <= S_RUN;
               end
            end
            S_RUN: begin
               if (bp_any) begin
                  halt_cause <= C_BP;
                  state      <= S_HALTED;
               end else if (halt_req) begin
                  halt_cause <= C_HOST;
                  state      <= S_HALTED;
               end else if (pc_valid) begin
                  bp_skip <= 1'b0;
               end
            end
            S_STEP: begin
               if (bp_any) begin
                  halt_cause <= C_BP;
                  state      <= S_HALTED;
               end else if (halt_req) begin
                  halt_cause <= C_HOST;
                  state      <= S_HALTED;
               end else if (step_ctr == '0) begin
                  halt_cause <= C_STEP;
                  state      <= S_HALTED;
               end else if (pc_valid) begin
                  bp_skip  <= 1'b0;
                  step_ctr <= step_ctr - STEP_ONE;
                  if (step_ctr == STEP_ONE) begin
                     halt_cause <= C_STEP;
                     state      <= S_HALTED;
                  end
               end
            end
            default: begin
               // Non-transfer modes complete in a single CMD cycle.
               if (!cmd_tx || done_sending) begin
                  rdata_reg <= data_internal;
                  cmd_done  <= 1'b1;
                  state     <= S_HALTED;
               end
            end
         endcase
      end
   end

endmodule
